// File: rtl/bcd_sched_pkg.sv
// bcd_sched_pkg: scheduler state encoding, blank BCD code and index-width helper
package bcd_sched_pkg;
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;
  localparam logic [3:0] BCD_BLANK = 4'hF;
  function automatic int unsigned clog2_min1(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bcd_conv_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; req_i+ptr_i in, one-hot gnt_o and idx_o out
module rr_arbiter
  import bcd_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IW      = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o
);
  always_comb begin
    idx_o = '0;
    gnt_o = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_i[IW'((int'(ptr_i) + i) % NUM_REQ)]) idx_o = IW'((int'(ptr_i) + i) % NUM_REQ);
    gnt_o[idx_o] = |req_i;
  end
endmodule

// File: rtl/bcd_conv_scheduler.sv
// bcd_conv_scheduler: round-robin time-share of one binary-to-BCD converter; req_*/rsp_* per requester, conv_* to converter, busy/timeout_err status
module bcd_conv_scheduler
  import bcd_sched_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int INPUT_WIDTH    = 8,
  parameter int DECIMAL_DIGITS = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          conv_start,
  output logic [INPUT_WIDTH-1:0]        conv_binary,
  input  logic [DECIMAL_DIGITS*4-1:0]   conv_bcd,
  input  logic                          conv_dv,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DECIMAL_DIGITS*4-1:0]   rsp_bcd,
  output logic                          busy,
  output logic                          timeout_err
);
  localparam int IW = clog2_min1(NUM_REQ);
  localparam int CW = clog2_min1(TIMEOUT_CYCLES);
  localparam int BW = DECIMAL_DIGITS * 4;
  state_t                 state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d, gidx_q, gidx_d, arb_idx;
  logic [NUM_REQ-1:0]     arb_gnt;
  logic [INPUT_WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]          cap_q, cap_d, bcd_q, bcd_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   dv_q, dv_d, err_q, err_d;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req_i(req_valid),
    .ptr_i(ptr_q),
    .gnt_o(arb_gnt),
    .idx_o(arb_idx)
  );
  assign conv_binary = bin_q;
  assign rsp_bcd     = bcd_q;
  assign timeout_err = err_q;
  assign busy        = state_q != S_IDLE;
  assign conv_start  = state_q == S_START;
  assign req_ready   = (state_q == S_IDLE) ? arb_gnt : '0;
  assign rsp_valid   = (state_q == S_DONE) ? NUM_REQ'(1) << gidx_q : '0;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    // converter result is registered once so rsp_bcd only changes on entry to DONE
    dv_d    = (state_q == S_WAIT) && conv_dv && !dv_q;
    cap_d   = ((state_q == S_WAIT) && conv_dv) ? conv_bcd : cap_q;
    case (state_q)
      S_IDLE: if (|req_valid) begin
        bin_d   = req_data[arb_idx*INPUT_WIDTH +: INPUT_WIDTH];
        gidx_d  = arb_idx;
        state_d = S_START;
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (dv_q) begin
          bcd_d   = cap_q;
          state_d = S_DONE;
        end else if (!conv_dv && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          bcd_d   = {DECIMAL_DIGITS{BCD_BLANK}};
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ptr_d   = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      bin_q   <= '0;
      cap_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      bin_q   <= bin_d;
      cap_q   <= cap_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// tb_bcd_conv_scheduler: table-driven and scoreboard bench for bcd_conv_scheduler with a behavioural converter
module tb_bcd_conv_scheduler;
  localparam int TO = 64, LAT = 4;
  typedef struct {int id; logic [11:0] bcd;} exp_t;
  typedef struct {int id; logic [7:0] data; logic [11:0] bcd;} vec_t;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] req_valid = '0, req_ready, rsp_valid, hold = '0, acc;
  logic [15:0] req_data = '0;
  logic conv_start, conv_dv = 1'b0, busy, timeout_err;
  logic [7:0] conv_binary, cv_val = '0;
  logic [11:0] conv_bcd = '0, rsp_bcd;
  int pass_cnt = 0, tot_cnt = 0, cyc = 0, start_cyc = 0, nstart = 0, cv_left = 0;
  bit stub = 0, inj = 0;
  logic [1:0] glog[$];
  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[8];
  always #5 clk = ~clk;
  bcd_conv_scheduler #(.NUM_REQ(2), .INPUT_WIDTH(8), .DECIMAL_DIGITS(3), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .conv_start(conv_start), .conv_binary(conv_binary), .conv_bcd(conv_bcd), .conv_dv(conv_dv),
    .rsp_valid(rsp_valid), .rsp_bcd(rsp_bcd), .busy(busy), .timeout_err(timeout_err)
  );
  function automatic logic [11:0] to_bcd(logic [7:0] v);
    int x;
    x = int'(v);
    return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tot_cnt++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask
  task automatic push(int id, logic [11:0] b);
    exp_t x;
    x.id = id;
    x.bcd = b;
    sb.push_back(x);
  endtask
  task automatic do_req(int id, logic [7:0] d, logic [11:0] b);
    logic [1:0] m;
    m = 2'(1 << id);
    push(id, b);
    @(posedge clk); #1;
    if (id == 1) req_data[15:8] = d; else req_data[7:0] = d;
    req_valid = req_valid | m;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((req_ready & m) != 0) begin
        chk("ready_onehot", req_ready, m);
        return;
      end
    end
    chk("accept_timeout", req_ready, m);
  endtask
  task automatic wait_idle(string n);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0 && req_valid == 0) return;
    end
    chk(n, sb.size(), 0);
  endtask
  task automatic wait_glog(int n);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (glog.size() >= n) return;
    end
    chk("glog_wait", glog.size(), n);
  endtask
  initial forever @(posedge clk) cyc++;
  initial forever begin
    @(negedge clk);
    conv_dv = 1'b0;
    if (reset) cv_left = 0;
    else if (conv_start) begin
      cv_left = LAT;
      cv_val = conv_binary;
    end else if (cv_left > 0) begin
      cv_left--;
      if (cv_left == 0 && !stub) begin
        conv_dv = 1'b1;
        conv_bcd = to_bcd(cv_val);
      end
    end
    if (inj) begin
      conv_dv = 1'b1;
      conv_bcd = 12'h999;
      inj = 0;
    end
  end
  initial forever begin
    @(negedge clk);
    acc = req_valid & req_ready;
    if (acc != 0) begin
      glog.push_back(acc);
      @(posedge clk); #1;
      req_valid = req_valid & ~(acc & ~hold);
    end
  end
  initial forever begin
    @(negedge clk);
    if (conv_start) begin
      start_cyc = cyc;
      nstart++;
    end
    if (rsp_valid != 0) begin
      if (sb.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
      else begin
        mon_e = sb.pop_front();
        chk("rsp_valid", rsp_valid, 1 << mon_e.id);
        chk("rsp_bcd", rsp_bcd, mon_e.bcd);
        chk("latency", cyc - start_cyc, stub ? TO + 1 : LAT + 2);
        chk("starts", nstart, 1);
        nstart = 0;
      end
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0] = '{0, 8'd255, 12'h255};
    tbl[1] = '{1, 8'd0,   12'h000};
    tbl[2] = '{0, 8'd7,   12'h007};
    tbl[3] = '{1, 8'd128, 12'h128};
    tbl[4] = '{0, 8'd99,  12'h099};
    tbl[5] = '{1, 8'd200, 12'h200};
    tbl[6] = '{0, 8'd10,  12'h010};
    tbl[7] = '{1, 8'd63,  12'h063};
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_start", conv_start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_binary", conv_binary, 0);
    chk("rst_bcd", rsp_bcd, 0);
    chk("rst_err", timeout_err, 0);
    foreach (tbl[i]) begin
      do_req(tbl[i].id, tbl[i].data, tbl[i].bcd);
      wait_idle("tbl_done");
      chk("conv_binary", conv_binary, tbl[i].data);
    end
    chk("no_timeout", timeout_err, 0);
    glog.delete();
    push(0, 12'h007);
    push(1, 12'h128);
    @(posedge clk); #1;
    req_data = {8'd128, 8'd7};
    req_valid = 2'b11;
    wait_idle("pair_done");
    chk("pair_n", glog.size(), 2);
    chk("pair_g0", glog[0], 2'b01);
    chk("pair_g1", glog[1], 2'b10);
    glog.delete();
    push(0, 12'h001);
    push(1, 12'h002);
    @(posedge clk); #1;
    req_data = {8'd2, 8'd1};
    req_valid = 2'b11;
    wait_idle("ptr_done");
    chk("ptr0_g0", glog[0], 2'b01);
    do_req(0, 8'd50, 12'h050);
    wait_idle("pre_alt");
    glog.delete();
    push(1, 12'h044);
    push(0, 12'h033);
    push(1, 12'h044);
    @(posedge clk); #1;
    hold = 2'b01;
    req_data = {8'd44, 8'd33};
    req_valid = 2'b11;
    wait_glog(1);
    @(posedge clk); #2;
    req_valid = req_valid | 2'b10;
    wait_glog(3);
    @(posedge clk); #2;
    hold = 2'b00;
    req_valid = 2'b00;
    wait_idle("alt_done");
    chk("alt_n", glog.size(), 3);
    chk("alt_g0", glog[0], 2'b10);
    chk("alt_g1", glog[1], 2'b01);
    chk("alt_g2", glog[2], 2'b10);
    stub = 1;
    do_req(0, 8'd42, 12'hFFF);
    wait_idle("to_done");
    chk("to_err", timeout_err, 1);
    stub = 0;
    do_req(1, 8'd9, 12'h009);
    wait_idle("post_to");
    chk("err_sticky", timeout_err, 1);
    @(posedge clk); #1;
    req_data[15:8] = 8'd5;
    req_valid = 2'b10;
    for (int i = 0; i < 50 && !conv_start; i++) @(negedge clk);
    chk("rst_test_start", conv_start, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    nstart = 0;
    chk("midrst_busy", busy, 0);
    chk("midrst_err", timeout_err, 0);
    chk("midrst_bcd", rsp_bcd, 0);
    chk("midrst_bin", conv_binary, 0);
    inj = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("late_dv_busy", busy, 0);
    end
    do_req(0, 8'd77, 12'h077);
    wait_idle("post_rst");
    inj = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stray_busy", busy, 0);
      chk("stray_rsp", rsp_valid, 0);
    end
    chk("stray_bcd", rsp_bcd, 12'h077);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
